hdmi_line_fetch_sched: RTL

Sequences DDR burst reads that refill the HDMI output pixel FIFO. Frame-start and next-line events from the HDMI timing core drive it. It splits each scan line into master burst requests, gates every burst on FIFO free space and tracks per-line credits. It sits between the HDMI timing core, the pixel FIFO and the bus master burst-read interface, and is configured from user-logic slave registers.

---
 rtl/hdmi_line_fetch_sched.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_line_fetch_sched.sv
// HDMI line fetch scheduler: splits each scan line into FIFO-gated DDR burst reads,
// paced by per-line credits granted by the timing core.
module hdmi_line_fetch_sched #(
    parameter int unsigned C_BURST_BYTES = 128,
    parameter int unsigned C_MAX_CREDITS = 3
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Reset,
    input  logic        start,
    input  logic        line_req,
    input  logic        frame_done,
    input  logic [31:0] FRAME_BASE_ADDR,
    input  logic [31:0] LINE_STRIDE,
    input  logic [31:0] NUM_BYTES_PER_PIXEL,
    input  logic [10:0] hres,
    input  logic [9:0]  vres,
    input  logic [9:0]  fifo_free,
    output logic        mst_req,
    output logic [31:0] mst_addr,
    output logic [11:0] mst_len,
    input  logic        mst_ack,
    input  logic        mst_cmplt,
    input  logic        mst_error,
    output logic        busy,
    output logic [9:0]  line_idx,
    output logic        err
);

    localparam int unsigned AW   = 32;
    localparam int unsigned LBW  = 14;
    localparam int unsigned LENW = 12;
    localparam int unsigned VW   = 10;
    localparam int unsigned CW   = $clog2(C_MAX_CREDITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARM, ST_SPACE, ST_REQ, ST_WAIT, ST_LDONE, ST_WLINE
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [AW-1:0]  r_line_addr, w_line_addr_nxt;
    logic [AW-1:0]  r_cur_addr, w_cur_addr_nxt;
    logic [AW-1:0]  r_stride_bytes, w_stride_nxt;
    logic [LBW-1:0] r_line_bytes, w_line_bytes_nxt;
    logic [LBW-1:0] r_off_left, w_off_left_nxt;
    logic [VW-1:0]  r_vres, w_vres_nxt;
    logic [CW-1:0]  r_credits, w_credits_nxt, w_cred_upd;
    logic           r_abort, w_abort_nxt;
    logic           r_restart, w_restart_nxt;
    logic [AW-1:0]  w_mst_addr_nxt;
    logic [LENW-1:0] w_mst_len_nxt, w_len;
    logic [VW-1:0]  w_line_idx_nxt, w_idx_inc;
    logic           w_err_nxt;
    logic           w_stop, w_cfg_ok, w_space_ok, w_cred_dec;
    logic           w_unused;

    assign w_unused   = ^NUM_BYTES_PER_PIXEL[31:3];
    assign w_stop     = frame_done | start;
    assign w_cfg_ok   = (hres != '0) && (vres != '0);
    assign w_len      = (r_off_left >= LBW'(C_BURST_BYTES)) ? LENW'(C_BURST_BYTES) : LENW'(r_off_left);
    assign w_space_ok = ({fifo_free, 2'b00} >= w_len);
    assign w_idx_inc  = line_idx + VW'(1);
    assign w_cred_dec = (r_state == ST_LDONE) && (r_credits != '0);

    // Credit counter: saturating increment; a same-cycle grant cancels the line-done decrement.
    always_comb begin
        w_cred_upd = r_credits;
        if (w_cred_dec && !line_req) begin
            w_cred_upd = r_credits - CW'(1);
        end else if (!w_cred_dec && line_req && (r_credits < CW'(C_MAX_CREDITS))) begin
            w_cred_upd = r_credits + CW'(1);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_line_addr_nxt  = r_line_addr;
        w_cur_addr_nxt   = r_cur_addr;
        w_stride_nxt     = r_stride_bytes;
        w_line_bytes_nxt = r_line_bytes;
        w_off_left_nxt   = r_off_left;
        w_vres_nxt       = r_vres;
        w_credits_nxt    = w_cred_upd;
        w_abort_nxt      = r_abort;
        w_restart_nxt    = r_restart;
        w_mst_addr_nxt   = mst_addr;
        w_mst_len_nxt    = mst_len;
        w_line_idx_nxt   = line_idx;
        w_err_nxt        = err;

        // A start during a frame aborts it and is replayed once IDLE is reached.
        if ((r_state != ST_IDLE) && start) begin
            w_restart_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (start || r_restart) begin
                    w_restart_nxt = 1'b0;
                    if (w_cfg_ok) begin
                        w_line_bytes_nxt = LBW'(hres) * LBW'(NUM_BYTES_PER_PIXEL[2:0]);
                        w_stride_nxt     = LINE_STRIDE * AW'(NUM_BYTES_PER_PIXEL[2:0]);
                        w_line_addr_nxt  = FRAME_BASE_ADDR;
                        w_vres_nxt       = vres;
                        w_credits_nxt    = CW'(1);
                        w_line_idx_nxt   = '0;
                        w_state_nxt      = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                w_off_left_nxt = r_line_bytes;
                w_cur_addr_nxt = r_line_addr;
                w_state_nxt    = w_stop ? ST_IDLE : ST_SPACE;
            end
            ST_SPACE: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_space_ok) begin
                    w_mst_addr_nxt = r_cur_addr;
                    w_mst_len_nxt  = w_len;
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_stop) begin
                    w_abort_nxt = 1'b1;
                end
                if (mst_ack) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_stop) begin
                    w_abort_nxt = 1'b1;
                end
                if (mst_cmplt) begin
                    if (mst_error) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cur_addr_nxt = r_cur_addr + AW'(mst_len);
                        w_off_left_nxt = r_off_left - LBW'(mst_len);
                        if (r_abort || w_stop) begin
                            w_state_nxt = ST_IDLE;
                        end else if (r_off_left == LBW'(mst_len)) begin
                            w_state_nxt = ST_LDONE;
                        end else begin
                            w_state_nxt = ST_SPACE;
                        end
                    end
                end
            end
            ST_LDONE: begin
                w_line_idx_nxt  = w_idx_inc;
                w_line_addr_nxt = r_line_addr + r_stride_bytes;
                if (w_stop || (w_idx_inc == r_vres)) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cred_upd != '0) begin
                    w_state_nxt = ST_ARM;
                end else begin
                    w_state_nxt = ST_WLINE;
                end
            end
            ST_WLINE: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_credits != '0) begin
                    w_state_nxt = ST_ARM;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_state_nxt == ST_IDLE) begin
            w_credits_nxt = '0;
            w_abort_nxt   = 1'b0;
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_state        <= ST_IDLE;
            r_line_addr    <= '0;
            r_cur_addr     <= '0;
            r_stride_bytes <= '0;
            r_line_bytes   <= '0;
            r_off_left     <= '0;
            r_vres         <= '0;
            r_credits      <= '0;
            r_abort        <= 1'b0;
            r_restart      <= 1'b0;
            mst_req        <= 1'b0;
            mst_addr       <= '0;
            mst_len        <= '0;
            busy           <= 1'b0;
            line_idx       <= '0;
            err            <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_line_addr    <= w_line_addr_nxt;
            r_cur_addr     <= w_cur_addr_nxt;
            r_stride_bytes <= w_stride_nxt;
            r_line_bytes   <= w_line_bytes_nxt;
            r_off_left     <= w_off_left_nxt;
            r_vres         <= w_vres_nxt;
            r_credits      <= w_credits_nxt;
            r_abort        <= w_abort_nxt;
            r_restart      <= w_restart_nxt;
            mst_req        <= (w_state_nxt == ST_REQ);
            mst_addr       <= w_mst_addr_nxt;
            mst_len        <= w_mst_len_nxt;
            busy           <= (w_state_nxt != ST_IDLE);
            line_idx       <= w_line_idx_nxt;
            err            <= w_err_nxt;
        end
    end

endmodule
